// File: rtl/regdump_pkg.sv
// State encoding shared by the register-file dump reader and its users.
package regdump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream carrying (id, data) pairs out of the dump reader.
interface regfile_dump_reader_if #(
    parameter int WORD_LENGTH = 16,
    parameter int ID_LENGTH   = 2
);
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_LENGTH-1:0]   out_id;
    logic [WORD_LENGTH-1:0] out_data;

    modport master (
        output out_valid,
        input  out_ready,
        output out_id,
        output out_data
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_id,
        input  out_data
    );
endinterface

// File: rtl/defines.sv
// Shared default sizing for the register-file debug readout path.
`ifndef REGDUMP_DEFINES_SV
`define REGDUMP_DEFINES_SV
`define REGDUMP_WORD_LENGTH 16
`define REGDUMP_ID_LENGTH 2
`endif

// File: rtl/regfile_dump_reader.sv
// Walks a register ID range on a spare register_file read port and streams (id, data) beats.
// Optional REGDUMP_SKIP_ZERO_EN drops beats whose register value is zero.
`include "defines.sv"

module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int WORD_LENGTH = `REGDUMP_WORD_LENGTH,
    parameter int ID_LENGTH   = `REGDUMP_ID_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ID_LENGTH-1:0]   start_id,
    input  logic [ID_LENGTH-1:0]   end_id,
    output logic [ID_LENGTH-1:0]   rf_read_reg,
    input  logic [WORD_LENGTH-1:0] rf_read_data,
    regfile_dump_reader_if.master  dump,
    output logic                   busy,
    output logic                   done,
    output logic [ID_LENGTH:0]     sent_count
);

    state_t                 state_q, state_d;
    logic [ID_LENGTH-1:0]   idx_q, idx_d;
    logic [ID_LENGTH-1:0]   end_q, end_d;
    logic [ID_LENGTH-1:0]   id_q, id_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [ID_LENGTH:0]     cnt_q, cnt_d;
    logic                   skip_beat;

`ifdef REGDUMP_SKIP_ZERO_EN
    assign skip_beat = (rf_read_data == '0);
`else
    assign skip_beat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            end_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            id_q    <= id_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = end_q;
        id_d    = id_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = start_id;
                    end_d   = end_id;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (skip_beat) begin
                    if (idx_q == end_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    data_d  = rf_read_data;
                    id_d    = idx_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (dump.out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (idx_q == end_q) begin
                        state_d = DONE;
                    end else begin
                        // index wraps naturally at NUM_REGS
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rf_read_reg    = idx_q;
    assign dump.out_valid = (state_q == SEND);
    assign dump.out_id    = id_q;
    assign dump.out_data  = data_q;
    assign busy           = (state_q == READ) || (state_q == SEND);
    assign done           = (state_q == DONE);
    assign sent_count     = cnt_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: vector table, hand sequences and randomized dumps.
module tb_regfile_dump_reader;

    localparam int W = 16;
    localparam int I = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [I-1:0] start_id, end_id, rf_read_reg;
    logic [W-1:0] rf_read_data;
    logic         busy, done;
    logic [I:0]   sent_count;
    logic [W-1:0] regs [N];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [I-1:0] id;
        logic [W-1:0] data;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        int s;
        int e;
        int pct;
        int n_all;
        int n_skip;
    } vec_t;

    always #5 clk = ~clk;

    assign rf_read_data = regs[rf_read_reg];

    regfile_dump_reader_if #(.WORD_LENGTH(W), .ID_LENGTH(I)) dif();

    regfile_dump_reader #(.WORD_LENGTH(W), .ID_LENGTH(I)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_id     (start_id),
        .end_id       (end_id),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .dump         (dif),
        .busy         (busy),
        .done         (done),
        .sent_count   (sent_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit emits(input logic [W-1:0] v);
`ifdef REGDUMP_SKIP_ZERO_EN
        return v != '0;
`else
        return 1'b1;
`endif
    endfunction

    // Expected beats: IDs s, s+1, ... e taken modulo N, values from the current regs
    function automatic int build_expected(input int s, input int e);
        int n, id;
        beat_t b;
        exp_q.delete();
        n = ((e - s + N) % N) + 1;
        for (int k = 0; k < n; k++) begin
            id = (s + k) % N;
            if (emits(regs[id])) begin
                b.id   = id[I-1:0];
                b.data = regs[id];
                exp_q.push_back(b);
            end
        end
        return exp_q.size();
    endfunction

    task automatic do_dump(input int s, input int e, input int pct,
                           input int stall_beat, input int busy_cyc);
        int    n_exp, beats, stall;
        bit    pending, seen_done, last_acc, timing;
        logic [I-1:0] hid;
        logic [W-1:0] hdata;
        beat_t b;
        n_exp     = build_expected(s, e);
        beats     = 0;
        stall     = 0;
        pending   = 0;
        seen_done = 0;
        last_acc  = 0;
        timing    = emits(regs[e]);
        @(negedge clk);
        start    = 1'b1;
        start_id = s[I-1:0];
        end_id   = e[I-1:0];
        dif.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("valid_latency_early", dif.out_valid, 0);
        check("rf_read_reg_start", rf_read_reg, s);
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (cyc == busy_cyc) begin
                start    = 1'b1;
                start_id = 2'($urandom_range(N - 1));
                end_id   = 2'($urandom_range(N - 1));
            end else begin
                start = 1'b0;
            end
            if (cyc == 1 && emits(regs[s]))
                check("valid_latency", dif.out_valid, 1);
            if (last_acc && timing)
                check("done_after_last", done, 1);
            last_acc = 0;
            if (done) begin
                seen_done = 1;
                check("busy_in_done", busy, 0);
                check("beats_left", exp_q.size(), 0);
                check("beat_total", beats, n_exp);
                check("sent_count", sent_count, n_exp);
            end
            if (dif.out_valid) begin
                if (pending) begin
                    check("hold_id", dif.out_id, hid);
                    check("hold_data", dif.out_data, hdata);
                end
                pending = 1;
                hid     = dif.out_id;
                hdata   = dif.out_data;
                if (beats == stall_beat && stall < 5) begin
                    dif.out_ready = 1'b0;
                    stall++;
                end else begin
                    dif.out_ready = ($urandom_range(99) < pct);
                end
                if (dif.out_ready) begin
                    beats++;
                    pending = 0;
                    stall   = 0;
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("beat_id", dif.out_id, b.id);
                        check("beat_data", dif.out_data, b.data);
                        if (exp_q.size() == 0) last_acc = 1;
                    end
                end
            end else begin
                dif.out_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("done_one_cycle", done, 0);
        check("valid_after_done", dif.out_valid, 0);
    endtask

    task automatic load_plan_regs();
        regs[0] = 16'h1111;
        regs[1] = 16'h0000;
        regs[2] = 16'h2222;
        regs[3] = 16'h3333;
    endtask

    initial begin
        vec_t tbl [6];
        int   exp_n;
        int   s, e;
        bit   got;

        tbl[0] = '{s: 0, e: 3, pct: 100, n_all: 4, n_skip: 3};
        tbl[1] = '{s: 3, e: 1, pct: 100, n_all: 3, n_skip: 2};
        tbl[2] = '{s: 2, e: 2, pct: 100, n_all: 1, n_skip: 1};
        tbl[3] = '{s: 1, e: 1, pct: 60,  n_all: 1, n_skip: 0};
        tbl[4] = '{s: 2, e: 1, pct: 50,  n_all: 4, n_skip: 3};
        tbl[5] = '{s: 1, e: 0, pct: 100, n_all: 4, n_skip: 3};

        rst      = 1'b1;
        start    = 1'b0;
        start_id = '0;
        end_id   = '0;
        dif.out_ready = 1'b0;
        load_plan_regs();
        repeat (2) @(negedge clk);
        check("rst_valid", dif.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", sent_count, 0);
        check("rst_rf_reg", rf_read_reg, 0);
        check("rst_out_id", dif.out_id, 0);
        check("rst_out_data", dif.out_data, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            do_dump(tbl[i].s, tbl[i].e, tbl[i].pct, -1, -1);
`ifdef REGDUMP_SKIP_ZERO_EN
            exp_n = tbl[i].n_skip;
`else
            exp_n = tbl[i].n_all;
`endif
            check("tbl_count", sent_count, exp_n);
        end

        // backpressure on beat 2, then start pulse while busy
        do_dump(0, 3, 100, 2, -1);
        do_dump(3, 1, 100, -1, 1);
        do_dump(0, 2, 70, 1, 2);

        // reset in the middle of SEND after one accepted beat
        @(negedge clk);
        start    = 1'b1;
        start_id = 2'd0;
        end_id   = 2'd3;
        dif.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = dif.out_valid;
        end
        check("rst_seq_valid1", got, 1);
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = dif.out_valid;
        end
        check("rst_seq_valid2", got, 1);
        check("rst_seq_count", sent_count, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", dif.out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", sent_count, 0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_held_idle", busy, 0);
        do_dump(2, 2, 100, -1, -1);
        check("after_rst_count", sent_count, 1);

        // randomized dumps against the range model
        for (int it = 0; it < 16; it++) begin
            for (int r = 0; r < N; r++)
                regs[r] = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            s = $urandom_range(N - 1);
            e = $urandom_range(N - 1);
            do_dump(s, e, $urandom_range(100, 30),
                    $urandom_range(3) - 1,
                    ($urandom_range(1) == 1) ? $urandom_range(2, 1) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/readout engine that sits on a spare read port of register_file, the reader counterpart to the write path.
- On a start pulse it walks a range of register IDs and drives each ID onto the register file read address.
- It captures each read value and streams it out as (id, data) beats over a valid/ready handshake.
- Used by the testbench and by the debug/trace path to dump architectural state without stalling the core.

Parameters:
- WORD_LENGTH, 16, width of one register word (matches register_file).
- ID_LENGTH, 2, width of a register ID. Local constant NUM_REGS = 2**ID_LENGTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump. Sampled only in IDLE.
- start_id  input  ID_LENGTH  first register ID to read. Sampled with start.
- end_id  input  ID_LENGTH  last register ID to read, inclusive. Sampled with start.
- rf_read_reg  output  ID_LENGTH  read address to register_file.
- rf_read_data  input  WORD_LENGTH  combinational read data from register_file.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- out_id  output  ID_LENGTH  register ID of the current beat.
- out_data  output  WORD_LENGTH  register value of the current beat.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the dump completes.
- sent_count  output  ID_LENGTH+1  number of beats accepted in the current or last dump.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0, including rf_read_reg=0 and sent_count=0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: start=1 loads idx<=start_id and end<=end_id, clears sent_count, and moves to READ. start=0 holds IDLE.
- rf_read_reg is driven from registered idx in every state, so it never glitches combinationally from start.
- READ (1 cycle): at the posedge, out_data<=rf_read_data, out_id<=idx, out_valid<=1, and state moves to SEND.
- SEND: out_valid=1. out_data and out_id are held stable while out_ready=0, with no timeout.
- SEND with out_ready=1 (handshake): out_valid<=0 and sent_count increments.
  - If idx==end, go to DONE.
  - Otherwise idx<=idx+1 modulo NUM_REGS and go to READ.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Range and wrap-around:
  - idx wraps NUM_REGS-1 -> 0.
  - end_id < start_id dumps through the wrap: e.g. start 3, end 1 with NUM_REGS 4 reads 3,0,1.
  - start_id==end_id gives exactly one beat.
  - A full sweep is start_id = end_id+1 (mod NUM_REGS), giving NUM_REGS beats. sent_count is ID_LENGTH+1 bits so the value NUM_REGS fits.
- Latency: start at edge N gives out_valid high after edge N+1, i.e. at the second edge counting from the start edge.
  - With out_ready tied to 1, throughput is one beat per 2 cycles.
  - done is asserted in the cycle after the final handshake.
- start while busy: ignored, with no effect on the range or the counters.
- The register file may be written during a dump. Each beat reflects rf_read_data as sampled at that beat's READ edge.
- Reset asserted mid-dump aborts immediately: no done pulse and sent_count=0.

Optional Feature:
- Macro: REGDUMP_SKIP_ZERO_EN.
- Defined: in READ, if rf_read_data==0 then no beat is produced.
  - If idx==end, go to DONE; otherwise increment idx and stay in READ.
  - sent_count counts only emitted beats.
  - An all-zero range ends in DONE with sent_count=0 and out_valid never asserted.
- Undefined: every ID in the range is emitted, zero values included.

Decomposition:
- Shared package regdump_pkg holds the state enum (IDLE, READ, SEND, DONE) in a 2-bit typedef.
- Include the common defines.sv.
- One module is sufficient. The wrap-around index counter is too small to warrant a sub-module.

Test Plan:
- Init regs {0:0x1111, 1:0x0000, 2:0x2222, 3:0x3333}; start 0..3 with out_ready=1 -> beats (0,0x1111),(1,0x0000),(2,0x2222),(3,0x3333), done once, sent_count=4.
  - With REGDUMP_SKIP_ZERO_EN defined, the same stimulus gives 3 beats, ID 1 absent, sent_count=3.
- Wrap range: start_id=3, end_id=1 -> IDs 3,0,1 in order, sent_count=3.
- Backpressure: out_ready low for 5 cycles on beat 2 -> out_id and out_data are stable throughout, and no beat is duplicated or dropped.
- Pulse start again while busy -> ignored; the original range completes unchanged.
- Assert rst mid-SEND -> out_valid, busy, done and sent_count go to 0 asynchronously. A following start 2..2 gives exactly one beat.
- Single register start_id=end_id=2 with out_ready=1 -> out_valid high after the second edge from start, done asserted in the cycle after the handshake.
